// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter sharing one slave port among N_CLIENTS clients that
//   use the rq/ack handshake. A winning request is latched, presented to the
//   slave until s_ready (or until TIMEOUT cycles elapse), and then
//   acknowledged with a one-cycle ack pulse to the granted client.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   rq, wr_ni       : per-client request and direction (0 = write, 1 = read)
//   addr, wdata     : per-client address / write data, client i at [i*W +: W]
//   ack             : one-hot, one-cycle completion pulse
//   rdata           : last read result, valid in the ack cycle of a read
//   s_valid, s_wr_ni, s_addr, s_wdata : latched transaction to the slave
//   s_ready, s_rdata: slave completion and read data
//   grant_id        : current/last granted client
//   busy            : transaction in progress (ISSUE or ACK)
//   timeout_err     : one-cycle pulse with ack when the slave timed out
module bus_arbiter #(
    parameter int unsigned N_CLIENTS = 4,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_CLIENTS-1:0]          rq,
    input  logic [N_CLIENTS-1:0]          wr_ni,
    input  logic [N_CLIENTS*ADDR_W-1:0]   addr,
    input  logic [N_CLIENTS*DATA_W-1:0]   wdata,
    output logic [N_CLIENTS-1:0]          ack,
    output logic [DATA_W-1:0]             rdata,
    output logic                          s_valid,
    output logic                          s_wr_ni,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [DATA_W-1:0]             s_wdata,
    input  logic                          s_ready,
    input  logic [DATA_W-1:0]             s_rdata,
    output logic [$clog2(N_CLIENTS)-1:0]  grant_id,
    output logic                          busy,
    output logic                          timeout_err
);

    localparam int unsigned GW = $clog2(N_CLIENTS);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ACK
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [GW-1:0]   last_grant;
    logic [GW-1:0]   sel;
    logic [GW-1:0]   idx;
    logic            sel_found;
    logic [CW-1:0]   wait_cnt;
    logic            to_flag;
    logic            expire;

    // The counter holds the number of ISSUE cycles already spent without
    // s_ready, so the TIMEOUT-th such cycle is the one that sees TIMEOUT-1.
    assign expire = (state == ISSUE) && !s_ready && (wait_cnt == CW'(TIMEOUT - 1));

    // Round-robin search starting just after the last granted client.
    always_comb begin
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int unsigned off = 1; off <= N_CLIENTS; off++) begin
            idx = GW'((32'(last_grant) + off) % N_CLIENTS);
            if (!sel_found && rq[idx]) begin
                sel       = idx;
                sel_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (sel_found) state_nxt = ISSUE;
            ISSUE:   if (s_ready || expire) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode: registered state and grant only
    always_comb begin
        ack           = '0;
        s_valid       = (state == ISSUE);
        busy          = (state == ISSUE) || (state == ACK);
        timeout_err   = (state == ACK) && to_flag;
        if (state == ACK) begin
            ack[grant_id] = 1'b1;
        end
    end

    // Transaction latch, wait counter, read data and grant history
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GW'(N_CLIENTS - 1);
            grant_id   <= '0;
            s_wr_ni    <= 1'b0;
            s_addr     <= '0;
            s_wdata    <= '0;
            rdata      <= '0;
            wait_cnt   <= '0;
            to_flag    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_found) begin
                        grant_id <= sel;
                        s_wr_ni  <= wr_ni[sel];
                        s_addr   <= addr[sel*ADDR_W +: ADDR_W];
                        s_wdata  <= wdata[sel*DATA_W +: DATA_W];
                        wait_cnt <= '0;
                        to_flag  <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (s_ready) begin
                        if (s_wr_ni) rdata <= s_rdata;
                    end else begin
                        if (wait_cnt != CW'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                        if (expire) begin
                            to_flag <= 1'b1;
                            if (s_wr_ni) rdata <= '0;
                        end
                    end
                end
                ACK: begin
                    last_grant <= grant_id;
                    wait_cnt   <= '0;
                    to_flag    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed stimulus for bus_arbiter with a transaction-level reference
//   model checked against every output on every cycle, plus literal
//   expectations at the key points of each scenario.
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      rq = '0;
    logic [N-1:0]      wr_ni = '1;
    logic [N*AW-1:0]   addr = '0;
    logic [N*DW-1:0]   wdata = '0;
    logic              s_ready = 1'b0;
    logic [DW-1:0]     s_rdata = '0;
    logic [N-1:0]      ack;
    logic [DW-1:0]     rdata;
    logic              s_valid;
    logic              s_wr_ni;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic              timeout_err;

    bus_arbiter #(
        .N_CLIENTS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rq          (rq),
        .wr_ni       (wr_ni),
        .addr        (addr),
        .wdata       (wdata),
        .ack         (ack),
        .rdata       (rdata),
        .s_valid     (s_valid),
        .s_wr_ni     (s_wr_ni),
        .s_addr      (s_addr),
        .s_wdata     (s_wdata),
        .s_ready     (s_ready),
        .s_rdata     (s_rdata),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is pending (phase 1) for as many cycles
    // as the slave takes, then acknowledged for one cycle (phase 2).
    int            m_phase = 0;
    int            m_last  = N - 1;
    int            m_gid   = 0;
    int            m_wait  = 0;
    bit            m_to    = 1'b0;
    bit            m_wr    = 1'b0;
    bit            m_found;
    logic [DW-1:0] m_rdata = '0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_wdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = 0; m_last = N - 1; m_gid = 0; m_wait = 0; m_to = 1'b0;
            m_wr = 1'b0; m_rdata = '0; m_addr = '0; m_wdata = '0;
        end else if (m_phase == 0) begin
            if (rq != '0) begin
                m_found = 1'b0;
                for (int k = 1; k <= N; k++) begin
                    if (!m_found && rq[(m_last + k) % N]) begin
                        m_gid   = (m_last + k) % N;
                        m_found = 1'b1;
                    end
                end
                m_wr    = wr_ni[m_gid];
                m_addr  = addr[m_gid*AW +: AW];
                m_wdata = wdata[m_gid*DW +: DW];
                m_wait  = 0;
                m_to    = 1'b0;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            m_wait++;
            if (s_ready) begin
                if (m_wr) m_rdata = s_rdata;
                m_phase = 2;
            end else if (m_wait == TO) begin
                m_to = 1'b1;
                if (m_wr) m_rdata = '0;
                m_phase = 2;
            end
        end else begin
            m_last  = m_gid;
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        check("m_s_valid",     32'(s_valid),     32'(m_phase == 1));
        check("m_busy",        32'(busy),        32'(m_phase != 0));
        check("m_ack",         32'(ack),         (m_phase == 2) ? 32'(1 << m_gid) : 32'd0);
        check("m_timeout_err", 32'(timeout_err), 32'((m_phase == 2) && m_to));
        check("m_grant_id",    32'(grant_id),    32'(m_gid));
        check("m_rdata",       32'(rdata),       32'(m_rdata));
        check("m_s_addr",      32'(s_addr),      32'(m_addr));
        check("m_s_wdata",     32'(s_wdata),     32'(m_wdata));
        check("m_s_wr_ni",     32'(s_wr_ni),     32'(m_wr));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_client(input int c, input bit rd, input logic [7:0] a, input logic [7:0] d);
        wr_ni[c]           = rd;
        addr[c*AW +: AW]   = a;
        wdata[c*DW +: DW]  = d;
    endtask

    // Returns at the negedge where ack is visible, or flags an expired bound.
    task automatic wait_ack(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (ack != '0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("ack_arrived", 32'(ok), 32'd1);
    endtask

    int nb;
    int cnt;

    initial begin
        // Reset values
        tick(); tick();
        check("rst_ack",      32'(ack),         32'h0);
        check("rst_rdata",    32'(rdata),       32'h0);
        check("rst_s_valid",  32'(s_valid),     32'h0);
        check("rst_grant",    32'(grant_id),    32'h0);
        check("rst_busy",     32'(busy),        32'h0);
        check("rst_timeout",  32'(timeout_err), 32'h0);
        rst = 1'b0;

        // Single write from client 2, slave always ready
        set_client(2, 1'b0, 8'h3C, 8'hA5);
        s_ready = 1'b1;
        rq = 4'b0100;
        tick();
        check("wr_s_valid", 32'(s_valid),  32'h1);
        check("wr_s_addr",  32'(s_addr),   32'h3C);
        check("wr_s_wdata", 32'(s_wdata),  32'hA5);
        check("wr_s_wr_ni", 32'(s_wr_ni),  32'h0);
        check("wr_grant",   32'(grant_id), 32'h2);
        tick();
        check("wr_ack",     32'(ack),      32'b0100);
        check("wr_rdata",   32'(rdata),    32'h0);
        rq = '0;
        tick();
        check("wr_idle_busy",  32'(busy),     32'h0);
        check("wr_idle_grant", 32'(grant_id), 32'h2);

        // Read from client 1, slave ready on the 3rd ISSUE cycle
        s_ready = 1'b0;
        set_client(1, 1'b1, 8'h10, 8'h00);
        rq = 4'b0010;
        nb = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (busy) nb++;
        end
        s_ready = 1'b1;
        s_rdata = 8'h5E;
        tick();
        if (busy) nb++;
        check("rd_ack",   32'(ack),   32'b0010);
        check("rd_rdata", 32'(rdata), 32'h5E);
        rq = '0;
        s_ready = 1'b0;
        tick();
        if (busy) nb++;
        check("rd_busy_cycles", 32'(nb), 32'd4);

        // Round-robin fairness from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < N; c++) set_client(c, 1'b1, 8'(8'h40 + c), 8'h00);
        s_ready = 1'b1;
        s_rdata = 8'h33;
        rq = 4'b1111;
        for (int i = 0; i < N; i++) begin
            wait_ack(10);
            check("rr_ack", 32'(ack), 32'(1 << i));
            tick();
            rq[i] = 1'b0;
        end
        rq = 4'b1001;
        wait_ack(10);
        check("rr_pair_first", 32'(ack), 32'b0001);
        tick();
        wait_ack(10);
        check("rr_pair_second", 32'(ack),      32'b1000);
        check("rr_pair_grant",  32'(grant_id), 32'h3);
        check("rr_rdata",       32'(rdata),    32'h33);
        tick();
        rq = '0;
        tick();

        // Timeout: client 0 read, slave never ready
        s_ready = 1'b0;
        set_client(0, 1'b1, 8'h77, 8'h00);
        rq = 4'b0001;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (ack != '0) break;
            if (s_valid) cnt++;
        end
        check("to_valid_cycles", 32'(cnt),         32'd15);
        check("to_ack",          32'(ack),         32'b0001);
        check("to_err",          32'(timeout_err), 32'h1);
        check("to_rdata",        32'(rdata),       32'h0);
        tick();
        rq = '0;
        check("to_err_pulse", 32'(timeout_err), 32'h0);
        tick();

        // Normal write right after the timeout
        set_client(1, 1'b0, 8'h21, 8'hC3);
        s_ready = 1'b1;
        rq = 4'b0010;
        tick(); tick();
        check("post_to_ack",   32'(ack),         32'b0010);
        check("post_to_err",   32'(timeout_err), 32'h0);
        check("post_to_rdata", 32'(rdata),       32'h0);
        tick();
        rq = '0;
        tick();

        // Expiry race: s_ready arrives on the last allowed ISSUE cycle
        s_ready = 1'b0;
        s_rdata = 8'h77;
        set_client(0, 1'b1, 8'h20, 8'h00);
        rq = 4'b0001;
        cnt = 0;
        for (int i = 0; i < TO; i++) begin
            tick();
            if (s_valid) cnt++;
        end
        s_ready = 1'b1;
        tick();
        check("race_valid_cycles", 32'(cnt),         32'd15);
        check("race_ack",          32'(ack),         32'b0001);
        check("race_err",          32'(timeout_err), 32'h0);
        check("race_rdata",        32'(rdata),       32'h77);
        tick();
        rq = '0;
        s_ready = 1'b0;
        tick();

        // Reset during the 2nd ISSUE cycle
        set_client(2, 1'b0, 8'h55, 8'h66);
        rq = 4'b0100;
        tick(); tick();
        check("mid_rst_pre_valid", 32'(s_valid), 32'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(s_valid),  32'h0);
        check("mid_rst_ack",   32'(ack),      32'h0);
        check("mid_rst_grant", 32'(grant_id), 32'h0);
        check("mid_rst_busy",  32'(busy),     32'h0);
        check("mid_rst_rdata", 32'(rdata),    32'h0);
        rst = 1'b0;
        rq = '0;
        tick();
        set_client(3, 1'b0, 8'h9A, 8'h5A);
        s_ready = 1'b1;
        rq = 4'b1000;
        tick(); tick();
        check("after_rst_ack3", 32'(ack), 32'b1000);
        tick();
        rq = '0;
        tick();
        set_client(0, 1'b0, 8'h01, 8'h02);
        rq = 4'b1001;
        tick(); tick();
        check("after_rst_pair", 32'(ack), 32'b0001);
        tick();
        rq = '0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin bus arbiter sharing one slave port among N_CLIENTS client controllers that use the rq/ack handshake. Each client drives a request with direction (wr_ni), address and write data. The arbiter grants one client, forwards the latched transaction to the slave, waits for slave completion, then returns a one-cycle ack (and read data) to the granted client. It sits between the client_control_logic instances and the shared memory/slave.

## Interface
- N_CLIENTS, 4: number of requesters, 2..8.
- ADDR_W, 8: address width.
- DATA_W, 8: data width.
- TIMEOUT, 15: max ISSUE cycles waiting for s_ready, ≥1.
- Reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- rq  in  N_CLIENTS  per-client request, held until ack.
- wr_ni  in  N_CLIENTS  per-client direction: 0 = write, 1 = read.
- addr  in  N_CLIENTS*ADDR_W  client i address in bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_CLIENTS*DATA_W  client i write data, same packing.
- ack  out  N_CLIENTS  one-hot, one-cycle completion pulse to the granted client.
- rdata  out  DATA_W  last read result; valid in the ack cycle of a read.
- s_valid  out  1  transaction presented to slave.
- s_wr_ni  out  1  latched direction.
- s_addr  out  ADDR_W  latched address.
- s_wdata  out  DATA_W  latched write data.
- s_ready  in  1  slave accepts/completes in this cycle (when s_valid=1).
- s_rdata  in  DATA_W  slave read data, sampled with s_ready.
- grant_id  out  clog2(N_CLIENTS)  index of current/last granted client.
- busy  out  1  high in ISSUE and ACK.
- timeout_err  out  1  one-cycle pulse, coincident with ack, on slave timeout.

## Operation
- FSM states: IDLE, ISSUE, ACK.
- IDLE: if any rq bit high, select the first requester searching from (last_grant+1) mod N_CLIENTS upward with wrap. Register grant_id, wr_ni/addr/wdata of that client into s_* registers. Go to ISSUE. If no rq, stay.
- ISSUE: s_valid=1 with latched s_* fields; client inputs ignored (changes have no effect).
  - s_ready=1: for a read, rdata <= s_rdata. Go to ACK.
  - Otherwise, increment wait counter. When the counter reaches TIMEOUT with s_ready still low, go to ACK with timeout flag set; for a read, rdata <= 0.
  - If s_ready=1 in the expiry cycle, it wins: normal completion, no timeout.
- ACK: ack[grant_id]=1 for exactly one cycle; timeout_err=1 if flagged. last_grant <= grant_id. Clear the counter and flag. Go to IDLE.
- rq is not sampled in ISSUE or ACK. Clients must drop rq no later than the first IDLE cycle after ack; the client controller's WAIT_ACK exit satisfies this.
- On a write, rdata holds its previous value.
- s_addr, s_wdata and s_wr_ni hold their last values outside ISSUE. Only s_valid qualifies them.
- Wait counter width is clog2(TIMEOUT+1); it never wraps.
- Reset values: state IDLE, last_grant = N_CLIENTS-1 (client 0 has priority after reset). ack, rdata, s_valid, s_wr_ni, s_addr, s_wdata, grant_id, busy and timeout_err are all 0.
- Reset mid-transaction: on the next edge all of the above are restored. The transaction is abandoned, no ack is issued, and s_valid drops.

## Timing
- rq seen high in IDLE at cycle T → s_valid high at T+1.
- s_ready at T+1+k (k < TIMEOUT) → ack at T+2+k → IDLE at T+3+k.
- Minimum rq-to-ack latency is 2 cycles; maximum throughput is one transaction per 3 cycles.
- Timeout: ack and timeout_err at T+1+TIMEOUT. s_valid is high for exactly TIMEOUT cycles.
- grant_id is valid from T+1 and held through ACK and the following IDLE cycles.
- busy = (state==ISSUE)|(state==ACK); it is a registered-state decode with no combinational path from rq.
- ack and timeout_err are decoded from registered state and grant_id; there is no combinational path from any input.

## Test plan
- Single write, N_CLIENTS=4: client 2 asserts rq, wr_ni=0, addr=0x3C, wdata=0xA5; s_ready tied 1 → s_valid for 1 cycle with s_addr=0x3C, s_wdata=0xA5, s_wr_ni=0; ack=4'b0100 two cycles after rq; rdata unchanged.
- Read with slave delay: client 1 reads addr=0x10; s_ready asserted on the 3rd ISSUE cycle with s_rdata=0x5E → ack=4'b0010 the next cycle with rdata=0x5E; busy high for 4 cycles.
- Round-robin fairness: all four rq held high after reset, each dropped one cycle after its ack → grants 0,1,2,3. Then clients 0 and 3 re-request together → grant 0; next, 3 and 0 together → grant 3.
- Timeout: TIMEOUT=15, client 0 read, s_ready stuck 0 → s_valid high 15 cycles; ack=4'b0001 and timeout_err=1 in the same cycle; rdata=0; next request served normally.
- Expiry race: s_ready=1 exactly on the 15th ISSUE cycle with s_rdata=0x77 → normal completion, timeout_err=0, rdata=0x77.
- Reset mid-ISSUE: rst pulsed during the 2nd ISSUE cycle → next cycle s_valid=0, ack=0, grant_id=0, busy=0. A following request from client 3 alone is granted; if clients 0 and 3 request together, 0 wins.
